pad_stream_gen: RTL

Zero-padding stream generator that sits directly upstream of the 3x3 line-buffer window stage. It accepts a raw raster-order image of `image_size` x `image_size` pixels over a valid/ready handshake. It emits the padded raster stream of (image_size+2*padding)^2 pixels, one per write strobe, inserting zero pixels for the border. Its `out_valid` drives the window stage's `wr_en` directly, and `out_pixel` drives its `input_pixel`.

---
 rtl/pad_stream_gen_pkg.sv | 19 +
 rtl/pad_stream_gen.sv | 91 +++++++++
 2 files changed

// File: rtl/pad_stream_gen_pkg.sv
// Shared constants for the padded-raster stream: state encoding and padded-width derivation.
// The window stage imports the same pad_width() so both sides agree on the padded row length.
package pad_stream_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pad_state_t;

    function automatic int pad_width(input int image_size, input int padding);
        return image_size + 2 * padding;
    endfunction

    // Row/col counter width; kept at least one bit so a 1x1 frame still elaborates.
    function automatic int cnt_width(input int pw);
        return (pw > 1) ? $clog2(pw) : 1;
    endfunction

endpackage

// File: rtl/pad_stream_gen.sv
// Zero-padding raster generator: turns an image_size^2 raw stream into a (image_size+2*padding)^2 padded stream.
// Latency 1 cycle input-to-output; one pixel per cycle when unstalled.
// Backpressure: in_ready only at data positions; no downstream backpressure (consumer takes every strobe).
module pad_stream_gen
    import pad_stream_gen_pkg::*;
#(
    parameter int image_size = 224,
    parameter int padding    = 1,
    parameter int bitsize    = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [bitsize-1:0] in_pixel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [bitsize-1:0] out_pixel,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int PW = pad_width(image_size, padding);
    localparam int CW = cnt_width(PW);
    localparam logic [CW-1:0] LAST = CW'(PW - 1);

    pad_state_t    state;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          is_pad;
    logic          advance;

    // With no border every position is data; the compare form would be constant-false.
    generate
        if (padding == 0) begin : g_nopad
            assign is_pad = 1'b0;
        end else begin : g_pad
            localparam logic [CW-1:0] LO = CW'(padding);
            localparam logic [CW-1:0] HI = CW'(padding + image_size);
            assign is_pad = (row < LO) || (row >= HI) || (col < LO) || (col >= HI);
        end
    endgenerate

    assign in_ready = (state == RUN) && !is_pad;
    assign advance  = (state == RUN) && (is_pad || in_valid);
    assign busy     = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            out_pixel  <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                RUN: begin
                    if (advance) begin
                        out_valid <= 1'b1;
                        out_pixel <= is_pad ? '0 : in_pixel;
                        if (col == LAST) begin
                            col <= '0;
                            if (row == LAST) begin
                                // Final position: leave RUN on the same edge that registers the last strobe.
                                row        <= '0;
                                state      <= IDLE;
                                frame_done <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
